// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/video single-port RAM arbiter with starvation guard and tagged read return
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_VID_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_starved
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CPU,
    SLOT_VID
  } slot_e;

  localparam logic [3:0] MAX_WAIT = 4'(MAX_VID_WAIT);

  slot_e                  slot;
  logic [3:0]             wait_cnt;
  logic [ADDR_W-1:0]      last_addr;
  logic [DATA_W-1:0]      last_wdata;
  logic [RD_LATENCY-1:0]  tag_valid;
  logic [RD_LATENCY-1:0]  tag_vid;
  logic                   rd_issue;

  assign vid_starved = (wait_cnt == MAX_WAIT);

  // Slot decision: CPU wins unless video has waited long enough; nothing is granted in reset
  always_comb begin
    slot = SLOT_IDLE;
    if (reset) begin
      if (cpu_req && !(vid_req && vid_starved)) begin
        slot = SLOT_CPU;
      end else if (vid_req) begin
        slot = SLOT_VID;
      end
    end
  end

  // RAM port mux; address and write data hold their last driven value on idle cycles
  always_comb begin
    cpu_gnt   = 1'b0;
    vid_gnt   = 1'b0;
    mem_addr  = last_addr;
    mem_we    = 1'b0;
    mem_wdata = last_wdata;
    case (slot)
      SLOT_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      SLOT_VID: begin
        vid_gnt  = 1'b1;
        mem_addr = vid_addr;
      end
      default: ;
    endcase
  end

  assign rd_issue = vid_gnt | (cpu_gnt & ~cpu_we);

  // Remember the last RAM address/data so idle cycles do not toggle the RAM pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr  <= '0;
      last_wdata <= '0;
    end else if (cpu_gnt) begin
      last_addr  <= cpu_addr;
      last_wdata <= cpu_wdata;
    end else if (vid_gnt) begin
      last_addr  <= vid_addr;
    end
  end

  // Count consecutive denied video cycles, saturating at the starvation threshold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (vid_req && !vid_gnt) begin
      if (wait_cnt != MAX_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Owner tags travel alongside the RAM read latency so each response reaches its issuer in order
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_vid   <= '0;
    end else begin
      tag_valid[0] <= rd_issue;
      tag_vid[0]   <= vid_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_vid[i]   <= tag_vid[i-1];
      end
    end
  end

  assign cpu_rvalid = tag_valid[RD_LATENCY-1] & ~tag_vid[RD_LATENCY-1];
  assign vid_rvalid = tag_valid[RD_LATENCY-1] &  tag_vid[RD_LATENCY-1];
  assign cpu_rdata  = mem_rdata;
  assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter, latency 1 and 3 instances
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_addr, vid_addr;
  logic [DW-1:0] cpu_wdata;

  logic [1:0]    cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid, mem_we, vid_starved;
  logic [DW-1:0] cpu_rdata [2];
  logic [DW-1:0] vid_rdata [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .MAX_VID_WAIT(MAXW)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt[0]), .vid_rvalid(vid_rvalid[0]), .vid_rdata(vid_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .vid_starved(vid_starved[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .MAX_VID_WAIT(MAXW)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt[1]), .vid_rvalid(vid_rvalid[1]), .vid_rdata(vid_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .vid_starved(vid_starved[1])
  );

  // RAM primitives (write-first), latency 1 and latency 3
  logic [DW-1:0] ram0 [1024];
  logic [DW-1:0] ram1 [1024];
  logic [DW-1:0] rp0, rp1_0, rp1_1, rp1_2;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = 16'(i) ^ 16'hA5A5;
      ram1[i] = 16'(i) ^ 16'hA5A5;
    end
  end

  always @(posedge clk) begin
    if (mem_we[0]) ram0[mem_addr[0][9:0]] <= mem_wdata[0];
    rp0 <= mem_we[0] ? mem_wdata[0] : ram0[mem_addr[0][9:0]];
    if (mem_we[1]) ram1[mem_addr[1][9:0]] <= mem_wdata[1];
    rp1_0 <= mem_we[1] ? mem_wdata[1] : ram1[mem_addr[1][9:0]];
    rp1_1 <= rp1_0;
    rp1_2 <= rp1_1;
  end
  assign mem_rdata[0] = rp0;
  assign mem_rdata[1] = rp1_2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: arbitration rules, shadow memory and a schedule of expected responses by cycle
  int            cyc = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_last = '0;
  logic [DW-1:0] shadow [1024];
  bit            s_val [2][16];
  bit            s_vid [2][16];
  logic [DW-1:0] s_dat [2][16];

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 16'(i) ^ 16'hA5A5;
    for (int k = 0; k < 2; k++) for (int j = 0; j < 16; j++) s_val[k][j] = 1'b0;
  end

  // Compare DUT outputs against the model every cycle, then advance the model
  always @(negedge clk) begin : model_cmp
    bit            e_st, e_cpu, e_vid, e_we, e_rd;
    logic [AW-1:0] e_addr;
    int            slot, idx, lat;
    slot = cyc % 16;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_cpu_gnt", 32'(cpu_gnt[k]), 0);
        chk("rst_vid_gnt", 32'(vid_gnt[k]), 0);
        chk("rst_mem_we", 32'(mem_we[k]), 0);
        chk("rst_mem_addr", 32'(mem_addr[k]), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid[k]), 0);
        chk("rst_vid_rvalid", 32'(vid_rvalid[k]), 0);
        chk("rst_starved", 32'(vid_starved[k]), 0);
        for (int j = 0; j < 16; j++) s_val[k][j] = 1'b0;
      end
      m_cnt  = 0;
      m_last = '0;
    end else begin
      e_st   = (m_cnt == MAXW);
      e_cpu  = cpu_req && !(vid_req && e_st);
      e_vid  = !e_cpu && vid_req;
      e_we   = e_cpu && cpu_we;
      e_rd   = e_vid || (e_cpu && !cpu_we);
      e_addr = e_cpu ? cpu_addr : (e_vid ? vid_addr : m_last);
      for (int k = 0; k < 2; k++) begin
        chk("cpu_gnt", 32'(cpu_gnt[k]), 32'(e_cpu));
        chk("vid_gnt", 32'(vid_gnt[k]), 32'(e_vid));
        chk("mem_we", 32'(mem_we[k]), 32'(e_we));
        chk("mem_addr", 32'(mem_addr[k]), 32'(e_addr));
        chk("vid_starved", 32'(vid_starved[k]), 32'(e_st));
        if (e_we) chk("mem_wdata", 32'(mem_wdata[k]), 32'(cpu_wdata));
        chk("cpu_rvalid", 32'(cpu_rvalid[k]), 32'(s_val[k][slot] && !s_vid[k][slot]));
        chk("vid_rvalid", 32'(vid_rvalid[k]), 32'(s_val[k][slot] && s_vid[k][slot]));
        if (s_val[k][slot]) begin
          if (s_vid[k][slot]) chk("vid_rdata", 32'(vid_rdata[k]), 32'(s_dat[k][slot]));
          else                chk("cpu_rdata", 32'(cpu_rdata[k]), 32'(s_dat[k][slot]));
        end
        s_val[k][slot] = 1'b0;
        lat = (k == 0) ? 1 : 3;
        if (e_rd) begin
          idx = (cyc + lat) % 16;
          s_val[k][idx] = 1'b1;
          s_vid[k][idx] = e_vid;
          s_dat[k][idx] = shadow[e_addr[9:0]];
        end
      end
      if (e_we) shadow[cpu_addr[9:0]] = cpu_wdata;
      if (vid_req && !e_vid) m_cnt = (m_cnt < MAXW) ? m_cnt + 1 : MAXW;
      else                   m_cnt = 0;
      m_last = e_addr;
    end
    cyc++;
  end

  // One cycle of stimulus applied just after the rising edge; returns at the following falling edge
  task automatic drive(input logic rst, input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic vreq, input logic [AW-1:0] vaddr);
    @(posedge clk);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vid_req = vreq; vid_addr = vaddr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  logic [DW-1:0] vexp [4];
  logic          c_req, c_we, v_req;
  logic [AW-1:0] c_addr, v_addr;
  logic [DW-1:0] c_wd;
  int            rst_left;

  initial begin
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
    vid_req = 1'b0; vid_addr = '0;

    // reset with a pending CPU request, then quiet release
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, '0);
      chk("t1_cpu_gnt", 32'(cpu_gnt[0]), 0);
      chk("t1_mem_we", 32'(mem_we[0]), 0);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t1_rvalid", 32'({cpu_rvalid, vid_rvalid}), 0);
    end

    // store then load the same address
    drive(1'b1, 1'b1, 1'b1, 16'h0010, 16'h0005, 1'b0, '0);
    chk("t2_st_gnt", 32'(cpu_gnt[0]), 1);
    chk("t2_st_we", 32'(mem_we[0]), 1);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, '0);
    chk("t2_ld_gnt", 32'(cpu_gnt[0]), 1);
    idle();
    chk("t2_rvalid_l1", 32'(cpu_rvalid[0]), 1);
    chk("t2_rdata_l1", 32'(cpu_rdata[0]), 32'h0005);
    idle();
    idle();
    chk("t2_rvalid_l3", 32'(cpu_rvalid[1]), 1);
    chk("t2_rdata_l3", 32'(cpu_rdata[1]), 32'h0005);

    // sustained contention: four CPU slots then one forced video slot
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0020, '0, 1'b1, 16'h0030);
      chk("t3_vid_gnt", 32'(vid_gnt[0]), 32'((i % 5) == 4));
      chk("t3_cpu_gnt", 32'(cpu_gnt[0]), 32'((i % 5) != 4));
      chk("t3_starved", 32'(vid_starved[0]), 32'((i % 5) == 4));
    end
    for (int i = 0; i < 4; i++) idle();

    // back-to-back video reads
    vexp[0] = 16'hA4A5; vexp[1] = 16'hA4A4; vexp[2] = 16'hA4A7; vexp[3] = 16'hA4A6;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0100 + 16'(j));
      else       idle();
      if (j < 4) chk("t4_vid_gnt", 32'(vid_gnt[0]), 1);
      if (j > 0) begin
        chk("t4_vid_rvalid", 32'(vid_rvalid[0]), 1);
        chk("t4_vid_rdata", 32'(vid_rdata[0]), 32'(vexp[j-1]));
      end
    end
    for (int i = 0; i < 4; i++) idle();

    // interleaved owners on the latency-3 instance
    drive(1'b1, 1'b1, 1'b0, 16'h0002, '0, 1'b1, 16'h0003);
    chk("t5_cpu_gnt", 32'(cpu_gnt[1]), 1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0003);
    chk("t5_vid_gnt", 32'(vid_gnt[1]), 1);
    idle();
    chk("t5_early", 32'({cpu_rvalid[1], vid_rvalid[1]}), 0);
    idle();
    chk("t5_cpu_rv", 32'({cpu_rvalid[1], vid_rvalid[1]}), 32'b10);
    chk("t5_cpu_rd", 32'(cpu_rdata[1]), 32'hA5A7);
    idle();
    chk("t5_vid_rv", 32'({cpu_rvalid[1], vid_rvalid[1]}), 32'b01);
    chk("t5_vid_rd", 32'(vid_rdata[1]), 32'hA5A6);
    idle();

    // reset with reads in flight
    drive(1'b1, 1'b1, 1'b0, 16'h0004, '0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 16'h0005, '0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t6_rvalid", 32'({cpu_rvalid, vid_rvalid}), 0);
    end

    // randomized traffic; requests held until granted, occasionally abandoned, rare resets
    c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; v_req = 0; v_addr = '0; rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!c_req || cpu_gnt[0] || $urandom_range(0, 99) < 4) begin
        c_req  = ($urandom_range(0, 99) < 60);
        c_we   = $urandom_range(0, 1) == 1;
        c_addr = 16'($urandom_range(0, 31));
        c_wd   = 16'($urandom);
      end
      if (!v_req || vid_gnt[0] || $urandom_range(0, 99) < 4) begin
        v_req  = ($urandom_range(0, 99) < 45);
        v_addr = 16'($urandom_range(0, 31));
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
      drive(rst_left == 0, c_req, c_we, c_addr, c_wd, v_req, v_addr);
    end
    for (int i = 0; i < 5; i++) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
